adder_rr_arbiter: RTL and testbench
===================================

Name: adder_rr_arbiter

Overview:
- Shares a single WIDTH-bit carry-in adder datapath between NUM_REQ requesters using round-robin arbitration.
- Each requester presents lhs/rhs/cin with a valid/ready handshake.
- The winner's sum and carry-out are captured in a one-entry output register and returned with the requester id over a valid/ready response channel.
- Sits between arithmetic clients and the shared adder datapath (out = lhs + rhs + cin, truncated to WIDTH; cout = carry out).

Parameters:
- WIDTH, 2, operand/result width in bits (>=1).
- NUM_REQ, 4, number of requesters (>=2).
- ID_W, clog2(NUM_REQ), width of the response id.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_lhs  in  NUM_REQ*WIDTH  packed lhs operands; requester i occupies bits [i*WIDTH +: WIDTH].
- req_rhs  in  NUM_REQ*WIDTH  packed rhs operands, same packing.
- req_cin  in  NUM_REQ  per-requester carry-in.
- resp_valid  out  1  result register holds a result.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  ID_W  index of the requester that produced the result.
- resp_out  out  WIDTH  sum, low WIDTH bits.
- resp_cout  out  1  carry-out of the sum.

Behaviour:
- One clock domain. Reset is synchronous and active-high. Ports are named clk and reset.
- Reset values: resp_valid=0, resp_id=0, resp_out=0, resp_cout=0, last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
- Output register state machine:
  - EMPTY: resp_valid=0.
  - FULL: resp_valid=1.
- can_accept = !resp_valid | resp_ready. The register may be refilled in the same cycle it drains.
- Arbitration is combinational:
  - Search req_valid starting at index (last_grant+1) mod NUM_REQ, wrapping.
  - The first set bit wins.
  - req_ready[winner] = can_accept; all other req_ready bits are 0.
  - If no req_valid bit is set, req_ready = 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- On a transfer (req_valid[w] & req_ready[w]) at clock edge:
  - {resp_cout, resp_out} <= lhs_w + rhs_w + cin_w, computed at WIDTH+1 bits.
  - resp_id <= w; resp_valid <= 1; last_grant <= w.
  - Latency is 1 cycle: the result is visible the cycle after acceptance.
- Drain without refill (resp_valid & resp_ready & no transfer): resp_valid <= 0. Data registers hold their values.
- Backpressure (resp_valid & !resp_ready): all req_ready=0; the output register and last_grant hold.
- last_grant updates only on a transfer, never on idle cycles.
- Fairness: with all requesters continuously valid and resp_ready=1, the grant order is 0,1,...,NUM_REQ-1,0,... with one grant per cycle. No requester waits more than NUM_REQ-1 grants.
- Arithmetic wrap: all-ones + all-ones + 1 gives out = all-ones and cout = 1.
- reset asserted mid-operation, including while FULL, has priority over everything:
  - Next cycle resp_valid=0 and last_grant=NUM_REQ-1.
  - req_ready is forced to 0 during the reset cycle.
  - Any pending result is discarded.
- Operands are sampled only on the transfer edge. Changes to lhs/rhs/cin after the transfer do not affect the held result.

Test Plan:
- Reset, then req_valid=0001, lhs0=1, rhs0=3, cin0=1, resp_ready=1 -> req_ready=0001. Next cycle resp_valid=1, resp_out=1, resp_cout=1, resp_id=0.
- All four requesters valid continuously, resp_ready=1, lhs_i=i, rhs_i=0, cin=0 -> resp_id sequence 0,1,2,3,0 on consecutive cycles, resp_out equal to resp_id, with a transfer every cycle.
- Hold resp_ready=0 after one result while requesters 1 and 2 are valid -> req_ready=0000 and the result is stable for 5 cycles. Raise resp_ready -> same-cycle refill with id 1, then id 2 next.
- Requester 3 valid alone after last_grant=3 -> wrap-around search grants 3 again. Operands lhs=3, rhs=3, cin=1 -> out=3, cout=1.
- Assert reset while resp_valid=1 -> next cycle resp_valid=0. With requesters 2 and 0 then valid, requester 0 is granted first.
- Idle cycles between grants (all req_valid=0 for 3 cycles) -> last_grant is unchanged. After a grant to 1, a subsequent request from 0 and 1 together goes to 0 before 1 only if it comes first after 1 in rotation: here the order is 0 then 1.

Source files
------------

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one carry-in adder between NUM_REQ clients.
// Result is held in a one-entry output register with valid/ready drain.
module adder_rr_arbiter #(
  parameter int WIDTH   = 2,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_lhs,
  input  logic [NUM_REQ*WIDTH-1:0] req_rhs,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_out,
  output logic                     resp_cout
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state;
  state_t          state_nx;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] winner;
  logic            found;
  logic            can_accept;
  logic            transfer;
  logic [WIDTH-1:0] lhs_w;
  logic [WIDTH-1:0] rhs_w;
  logic            cin_w;
  logic [WIDTH:0]  sum;

  assign resp_valid = (state == FULL);
  assign can_accept = !resp_valid | resp_ready;

  // Search starts just past the last winner and wraps.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[(int'(last_grant) + 1 + k) % NUM_REQ]) begin
        found  = 1'b1;
        winner = ID_W'((int'(last_grant) + 1 + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (found && can_accept && !reset)
      req_ready[winner] = 1'b1;
  end

  assign transfer = |(req_valid & req_ready);

  assign lhs_w = req_lhs[int'(winner)*WIDTH +: WIDTH];
  assign rhs_w = req_rhs[int'(winner)*WIDTH +: WIDTH];
  assign cin_w = req_cin[winner];
  assign sum   = {1'b0, lhs_w} + {1'b0, rhs_w} + (WIDTH+1)'(cin_w);

  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY: if (transfer) state_nx = FULL;
      FULL:  if (!transfer && resp_ready) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      last_grant <= ID_W'(NUM_REQ - 1);
      resp_id    <= '0;
      resp_out   <= '0;
      resp_cout  <= 1'b0;
    end else begin
      state <= state_nx;
      if (transfer) begin
        last_grant <= winner;
        resp_id    <= winner;
        {resp_cout, resp_out} <= sum;
      end
    end
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed self-checking bench for adder_rr_arbiter (WIDTH=2, NUM_REQ=4).
module tb_adder_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [7:0] req_lhs;
  logic [7:0] req_rhs;
  logic [3:0] req_cin;
  logic       resp_valid;
  logic       resp_ready;
  logic [1:0] resp_id;
  logic [1:0] resp_out;
  logic       resp_cout;

  int checks = 0;
  int errors = 0;

  adder_rr_arbiter #(.WIDTH(2), .NUM_REQ(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_lhs    (req_lhs),
    .req_rhs    (req_rhs),
    .req_cin    (req_cin),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_out   (resp_out),
    .resp_cout  (resp_cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_resp(input string tag, input logic v,
                          input logic [1:0] id, input logic [1:0] o,
                          input logic c);
    chk({tag, ".valid"}, 32'(resp_valid), 32'(v));
    chk({tag, ".id"},    32'(resp_id),    32'(id));
    chk({tag, ".out"},   32'(resp_out),   32'(o));
    chk({tag, ".cout"},  32'(resp_cout),  32'(c));
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 4'b0000;
    req_lhs    = 8'h00;
    req_rhs    = 8'h00;
    req_cin    = 4'b0000;
    resp_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk_resp("reset", 1'b0, 2'd0, 2'd0, 1'b0);
    chk("reset.ready", 32'(req_ready), 32'h0);

    // 1 + 3 + 1 = 5 -> out 1, cout 1
    req_valid = 4'b0001;
    req_lhs   = 8'h01;
    req_rhs   = 8'h03;
    req_cin   = 4'b0001;
    #1;
    chk("t1.ready", 32'(req_ready), 32'h1);
    tick();
    chk_resp("t1.resp", 1'b1, 2'd0, 2'd1, 1'b1);
    req_valid = 4'b0000;
    tick();
    chk("t1.drain", 32'(resp_valid), 32'h0);

    // Full rotation with lhs_i = i
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    req_valid = 4'b1111;
    req_lhs   = 8'he4;
    req_rhs   = 8'h00;
    req_cin   = 4'b0000;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2.ready%0d", k), 32'(req_ready),
          32'(4'b0001 << (k % 4)));
      tick();
      chk_resp($sformatf("t2.g%0d", k), 1'b1, 2'(k % 4), 2'(k % 4), 1'b0);
    end

    // Backpressure with 1 and 2 pending
    req_valid  = 4'b0110;
    resp_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3.bp_ready%0d", k), 32'(req_ready), 32'h0);
      tick();
      chk_resp($sformatf("t3.hold%0d", k), 1'b1, 2'd0, 2'd0, 1'b0);
    end
    resp_ready = 1'b1;
    #1;
    chk("t3.refill_ready", 32'(req_ready), 32'h2);
    tick();
    chk_resp("t3.id1", 1'b1, 2'd1, 2'd1, 1'b0);
    chk("t3.ready2", 32'(req_ready), 32'h4);
    tick();
    chk_resp("t3.id2", 1'b1, 2'd2, 2'd2, 1'b0);

    // Requester 3 alone, 3 + 3 + 1 = 7 -> out 3, cout 1
    req_valid = 4'b1000;
    req_rhs   = 8'hc0;
    req_cin   = 4'b1000;
    #1;
    chk("t4.ready_a", 32'(req_ready), 32'h8);
    tick();
    chk_resp("t4.a", 1'b1, 2'd3, 2'd3, 1'b1);
    chk("t4.ready_b", 32'(req_ready), 32'h8);
    tick();
    chk_resp("t4.b", 1'b1, 2'd3, 2'd3, 1'b1);
    req_valid  = 4'b0000;
    resp_ready = 1'b0;
    req_lhs    = 8'h00;
    req_rhs    = 8'h00;
    req_cin    = 4'b0000;
    tick();
    chk_resp("t4.held", 1'b1, 2'd3, 2'd3, 1'b1);

    // Reset while FULL
    req_lhs    = 8'he4;
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    reset      = 1'b1;
    #1;
    chk("t5.rst_ready", 32'(req_ready), 32'h0);
    tick();
    reset     = 1'b0;
    req_valid = 4'b0101;
    #1;
    chk("t5.flushed", 32'(resp_valid), 32'h0);
    chk("t5.ready0", 32'(req_ready), 32'h1);
    tick();
    chk_resp("t5.id0", 1'b1, 2'd0, 2'd0, 1'b0);
    chk("t5.ready2", 32'(req_ready), 32'h4);
    tick();
    chk_resp("t5.id2", 1'b1, 2'd2, 2'd2, 1'b0);

    // Grant 1, idle 3 cycles, then 0 and 1 together
    req_valid = 4'b0010;
    tick();
    chk_resp("t6.id1", 1'b1, 2'd1, 2'd1, 1'b0);
    req_valid = 4'b0000;
    for (int k = 0; k < 3; k++) tick();
    chk("t6.idle", 32'(resp_valid), 32'h0);
    req_valid = 4'b0011;
    #1;
    chk("t6.ready0", 32'(req_ready), 32'h1);
    tick();
    chk_resp("t6.g0", 1'b1, 2'd0, 2'd0, 1'b0);
    chk("t6.ready1", 32'(req_ready), 32'h2);
    tick();
    chk_resp("t6.g1", 1'b1, 2'd1, 2'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
